// File: rtl/cpu_run_ctrl_if.sv
// Host loader/debug access channel into the run controller: level request,
// one-cycle acknowledge strobe carrying read data.
interface cpu_run_ctrl_if #(
    parameter int ADDR_LEN = 14
);
    logic                host_req;
    logic                host_we;
    logic [ADDR_LEN-1:0] host_addr;
    logic [31:0]         host_wdata;
    logic                host_ack;
    logic [31:0]         host_rdata;

    modport master (
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata
    );

    modport slave (
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run controller for the single-port-RAM CPU: owns the RAM port mux, services host
// loads/readback, runs the CPU until halt/timeout/abort. Optional macro: BREAKPOINT_EN.
module cpu_run_ctrl #(
    parameter int ADDR_LEN   = 14,
    parameter int HALT_CNT   = 8,
    parameter int CYC_W      = 24,
    parameter int MAX_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    cpu_run_ctrl_if.slave       host,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                timeout,
    output logic [CYC_W-1:0]    cycle_count,
    output logic                cpu_rst,
    input  logic                cpu_wrEn,
    input  logic [ADDR_LEN-1:0] cpu_addr,
    input  logic [31:0]         cpu_wdata,
    input  logic [ADDR_LEN-1:0] cpu_pc,
    output logic [31:0]         cpu_rdata,
    output logic                ram_wrEn,
    output logic [ADDR_LEN-1:0] ram_addr,
    output logic [31:0]         ram_wdata,
    input  logic [31:0]         ram_rdata
`ifdef BREAKPOINT_EN
    ,
    input  logic                bp_en,
    input  logic [ADDR_LEN-1:0] bp_addr,
    output logic                bp_hit
`endif
);

    localparam int               HC_W      = $clog2(HALT_CNT + 1);
    localparam logic [HC_W-1:0]  HALT_LAST = HC_W'(HALT_CNT - 1);
    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(MAX_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HACC,
        S_ACK,
        S_RUN,
        S_STOP
    } state_t;

    state_t              state_q;
    logic                cpu_rst_q;
    logic                busy_q;
    logic                done_q;
    logic                ack_q;
    logic                timeout_q;
    logic [CYC_W-1:0]    cyc_q;
    logic [CYC_W-1:0]    cyc_d;
    logic [HC_W-1:0]     halt_q;
    logic [HC_W-1:0]     halt_d;
    logic [ADDR_LEN-1:0] prev_pc_q;

    logic pc_same;
    logic halt_end;
    logic cyc_end;
    logic bp_stop;

    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
        return (&v) ? v : v + CYC_W'(1);
    endfunction

    assign pc_same  = (cpu_pc == prev_pc_q);
    assign halt_end = pc_same && (halt_q == HALT_LAST);
    assign cyc_end  = (cyc_q == CYC_LAST);
    assign cyc_d    = sat_inc(cyc_q);
    assign halt_d   = pc_same ? halt_q + HC_W'(1) : '0;

`ifdef BREAKPOINT_EN
    logic bp_hit_q;
    assign bp_stop = bp_en && (cpu_pc == bp_addr);
    assign bp_hit  = bp_hit_q;
`else
    assign bp_stop = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
            cyc_q     <= '0;
            halt_q    <= '0;
            prev_pc_q <= '0;
`ifdef BREAKPOINT_EN
            bp_hit_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            ack_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cpu_rst_q <= 1'b1;
                    busy_q    <= 1'b0;
                    // Host access wins so a loader is never starved by a held start.
                    if (host.host_req) begin
                        state_q <= S_HACC;
                    end else if (start) begin
                        state_q   <= S_RUN;
                        cpu_rst_q <= 1'b0;
                        busy_q    <= 1'b1;
                        cyc_q     <= '0;
                        halt_q    <= '0;
                        timeout_q <= 1'b0;
`ifdef BREAKPOINT_EN
                        bp_hit_q  <= 1'b0;
`endif
                    end
                end
                S_HACC: begin
                    state_q <= S_ACK;
                    ack_q   <= 1'b1;
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                end
                S_RUN: begin
                    cyc_q     <= cyc_d;
                    prev_pc_q <= cpu_pc;
                    halt_q    <= halt_d;
                    if (abort || bp_stop || cyc_end || halt_end) begin
                        state_q   <= S_STOP;
                        cpu_rst_q <= 1'b1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end
                    // Only the highest-priority stop cause is recorded.
                    if (!abort) begin
                        if (bp_stop) begin
`ifdef BREAKPOINT_EN
                            bp_hit_q <= 1'b1;
`endif
                        end else if (cyc_end) begin
                            timeout_q <= 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q   <= S_IDLE;
                    cpu_rst_q <= 1'b1;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        ram_wrEn  = 1'b0;
        ram_addr  = host.host_addr;
        ram_wdata = '0;
        case (state_q)
            S_RUN: begin
                ram_wrEn  = cpu_wrEn;
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
            end
            S_HACC: begin
                ram_wrEn  = host.host_we;
                ram_addr  = host.host_addr;
                ram_wdata = host.host_wdata;
            end
            default: ;
        endcase
    end

    assign cpu_rdata       = ram_rdata;
    assign host.host_rdata = ram_rdata;
    assign host.host_ack   = ack_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign timeout         = timeout_q;
    assign cycle_count     = cyc_q;
    assign cpu_rst         = cpu_rst_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: host load/readback, halt, timeout, abort,
// host/start arbitration and reset mid-run, with a behavioural 1-cycle RAM.
module tb_cpu_run_ctrl;

    localparam int AL = 14;
    localparam int CW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy, done, timeout, cpu_rst;
    logic [CW-1:0] cycle_count;
    logic          cpu_wrEn = 1'b0;
    logic [AL-1:0] cpu_addr = '0;
    logic [31:0]   cpu_wdata = '0;
    logic [AL-1:0] cpu_pc = '0;
    logic [31:0]   cpu_rdata;
    logic          ram_wrEn;
    logic [AL-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata = '0;
`ifdef BREAKPOINT_EN
    logic          bp_en = 1'b0;
    logic [AL-1:0] bp_addr = '0;
    logic          bp_hit;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:(1<<AL)-1];

    cpu_run_ctrl_if #(.ADDR_LEN(AL)) hif ();

    cpu_run_ctrl #(
        .ADDR_LEN(AL), .HALT_CNT(8), .CYC_W(CW), .MAX_CYCLES(50)
    ) dut (
        .clk(clk), .rst(rst), .host(hif), .start(start), .abort(abort),
        .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count),
        .cpu_rst(cpu_rst), .cpu_wrEn(cpu_wrEn), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_pc(cpu_pc), .cpu_rdata(cpu_rdata),
        .ram_wrEn(ram_wrEn), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
`ifdef BREAKPOINT_EN
        , .bp_en(bp_en), .bp_addr(bp_addr), .bp_hit(bp_hit)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wrEn) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic host_xfer(input logic we, input logic [AL-1:0] a, input logic [31:0] d,
                             input logic [31:0] exp, input string tag);
        hif.host_req   = 1'b1;
        hif.host_we    = we;
        hif.host_addr  = a;
        hif.host_wdata = d;
        tick();
        chk({tag, "_ack_hacc"}, 32'(hif.host_ack), 32'd0);
        chk({tag, "_ram_we"}, 32'(ram_wrEn), 32'(we));
        chk({tag, "_ram_addr"}, 32'(ram_addr), 32'(a));
        tick();
        chk({tag, "_ack"}, 32'(hif.host_ack), 32'd1);
        chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
        if (!we) chk({tag, "_rdata"}, hif.host_rdata, exp);
        hif.host_req = 1'b0;
        tick();
        chk({tag, "_ack_off"}, 32'(hif.host_ack), 32'd0);
    endtask

    initial begin
        hif.host_req   = 1'b0;
        hif.host_we    = 1'b0;
        hif.host_addr  = '0;
        hif.host_wdata = '0;
        tick();
        tick();
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_cycles", 32'(cycle_count), 32'd0);
        chk("rst_ack", 32'(hif.host_ack), 32'd0);
        chk("idle_ram_we", 32'(ram_wrEn), 32'd0);
        rst = 1'b1;
        tick();

        // Host write then readback of the same word.
        host_xfer(1'b1, 14'd5, 32'h1234_5678, 32'h0, "hwr5");
        host_xfer(1'b0, 14'd5, 32'h0, 32'h1234_5678, "hrd5");
        host_xfer(1'b1, 14'd0, 32'hF000_0000, 32'h0, "hwr0");

        // Halt: PC parked at 0 for HALT_CNT run cycles.
        cpu_pc = 14'd0;
        start  = 1'b1;
        tick();
        chk("halt_busy0", 32'(busy), 32'd1);
        chk("halt_cpu_rst0", 32'(cpu_rst), 32'd0);
        chk("halt_cyc0", 32'(cycle_count), 32'd0);
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("halt_busy", 32'(busy), 32'd1);
            chk("halt_done_lo", 32'(done), 32'd0);
            cpu_wrEn = 1'b0;
            if (k == 3) begin
                cpu_wrEn  = 1'b1;
                cpu_addr  = 14'd9;
                cpu_wdata = 32'hCAFE_F00D;
                #1;
                chk("run_ram_we", 32'(ram_wrEn), 32'd1);
                chk("run_ram_addr", 32'(ram_addr), 32'd9);
                chk("run_ram_wdata", ram_wdata, 32'hCAFE_F00D);
            end
        end
        tick();
        chk("halt_done", 32'(done), 32'd1);
        chk("halt_busy_lo", 32'(busy), 32'd0);
        chk("halt_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("halt_timeout", 32'(timeout), 32'd0);
        chk("halt_cycles", 32'(cycle_count), 32'd8);
        tick();
        chk("halt_done_pulse", 32'(done), 32'd0);
        chk("halt_cyc_hold", 32'(cycle_count), 32'd8);
        host_xfer(1'b0, 14'd9, 32'h0, 32'hCAFE_F00D, "hrd9");

        // Timeout: PC never repeats, MAX_CYCLES = 50.
        cpu_pc = 14'd100;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 49; k++) begin
            cpu_pc = cpu_pc + 14'd1;
            tick();
            if (k == 20) chk("to_cyc20", 32'(cycle_count), 32'd20);
            if (busy !== 1'b1) chk("to_busy", 32'(busy), 32'd1);
        end
        cpu_pc = cpu_pc + 14'd1;
        tick();
        chk("to_done", 32'(done), 32'd1);
        chk("to_timeout", 32'(timeout), 32'd1);
        chk("to_cycles", 32'(cycle_count), 32'd50);
        chk("to_busy_lo", 32'(busy), 32'd0);
        tick();
        chk("to_sticky", 32'(timeout), 32'd1);

        // Abort 10 cycles into a run; start also clears timeout.
        cpu_pc = 14'd200;
        start  = 1'b1;
        tick();
        start = 1'b0;
        chk("ab_to_clr", 32'(timeout), 32'd0);
        chk("ab_cyc0", 32'(cycle_count), 32'd0);
        for (int k = 1; k <= 9; k++) begin
            cpu_pc = cpu_pc + 14'd1;
            tick();
        end
        abort  = 1'b1;
        cpu_pc = cpu_pc + 14'd1;
        tick();
        abort = 1'b0;
        chk("ab_done", 32'(done), 32'd1);
        chk("ab_timeout", 32'(timeout), 32'd0);
        chk("ab_cycles", 32'(cycle_count), 32'd10);
        tick();

        // host_req and start together: host first, then run; req during run waits.
        start = 1'b1;
        host_xfer(1'b0, 14'd9, 32'h0, 32'hCAFE_F00D, "pri");
        chk("pri_busy_idle", 32'(busy), 32'd0);
        cpu_pc = 14'd3;
        tick();
        chk("pri_busy_run", 32'(busy), 32'd1);
        start          = 1'b0;
        hif.host_req   = 1'b1;
        hif.host_we    = 1'b0;
        hif.host_addr  = 14'd5;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (hif.host_ack !== 1'b0) chk("run_no_ack", 32'(hif.host_ack), 32'd0);
            if (busy !== 1'b1) chk("pri_busy", 32'(busy), 32'd1);
        end
        tick();
        chk("pri_done", 32'(done), 32'd1);
        chk("pri_cycles", 32'(cycle_count), 32'd9);
        chk("pri_ack_stop", 32'(hif.host_ack), 32'd0);
        tick();
        chk("pri_ack_idle", 32'(hif.host_ack), 32'd0);
        tick();
        chk("pri_ack_hacc", 32'(hif.host_ack), 32'd0);
        tick();
        chk("pri_ack_late", 32'(hif.host_ack), 32'd1);
        chk("pri_rdata", hif.host_rdata, 32'h1234_5678);
        hif.host_req = 1'b0;
        tick();

        // Reset mid-run.
        cpu_pc = 14'd300;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            cpu_pc = cpu_pc + 14'd1;
            tick();
        end
        cpu_wrEn = 1'b1;
        cpu_addr = 14'd11;
        #1;
        chk("mr_ram_we_run", 32'(ram_wrEn), 32'd1);
        rst = 1'b0;
        #1;
        chk("mr_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_cycles", 32'(cycle_count), 32'd0);
        chk("mr_ram_we", 32'(ram_wrEn), 32'd0);
        cpu_wrEn = 1'b0;
        tick();
        chk("mr_no_done", 32'(done), 32'd0);
        rst = 1'b1;
        tick();
        chk("mr_idle_done", 32'(done), 32'd0);
        chk("mr_idle_busy", 32'(busy), 32'd0);

`ifdef BREAKPOINT_EN
        bp_en   = 1'b1;
        bp_addr = 14'd2;
        cpu_pc  = 14'd0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk("bp_clr", 32'(bp_hit), 32'd0);
        cpu_pc = 14'd1;
        tick();
        chk("bp_busy", 32'(busy), 32'd1);
        cpu_pc = 14'd2;
        tick();
        chk("bp_done", 32'(done), 32'd1);
        chk("bp_hit", 32'(bp_hit), 32'd1);
        chk("bp_timeout", 32'(timeout), 32'd0);
        bp_en = 1'b0;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
